mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter sharing the single main-memory data bus (`address`, `wr_data`, `read_data`, `wr_enable`, `write_length`) between the CPU data port (master 0) and a secondary master (master 1: program loader / DMA). It grants the bus with round-robin fairness and supports a bounded lock for back-to-back bursts. It multiplexes the granted master's request onto the RAM and returns read data with a one-cycle valid strobe. It sits between the CPU/loader and the RAM instance in the SoC.

## Interface
Parameters:
- `MAX_BURST`, 4: maximum consecutive beats a locked master keeps the bus while the other master requests (1..15).

Ports:
- `clk`  in  1  system clock; rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_m0_req`, `i_m1_req`  in  1  access request; held until granted beat completes.
- `i_m0_lock`, `i_m1_lock`  in  1  request to keep the bus after the current beat.
- `i_m0_address`, `i_m1_address`  in  32  byte address.
- `i_m0_wr_data`, `i_m1_wr_data`  in  32  write data.
- `i_m0_wr_enable`, `i_m1_wr_enable`  in  1  1 = write beat, 0 = read beat.
- `i_m0_write_length`, `i_m1_write_length`  in  3  RAM write length code, passed through unchanged.
- `o_m0_gnt`, `o_m1_gnt`  out  1  bus owned this cycle; a beat completes when gnt && req.
- `o_m0_read_data`, `o_m1_read_data`  out  32  registered read data.
- `o_m0_rvalid`, `o_m1_rvalid`  out  1  one-cycle strobe, read data valid.
- `o_mem_address`  out  32  to RAM.
- `o_mem_wr_data`  out  32  to RAM.
- `o_mem_wr_enable`  out  1  to RAM.
- `o_mem_write_length`  out  3  to RAM.
- `i_mem_read_data`  in  32  from RAM; valid in the same cycle as the address.

## Operation
- FSM states: IDLE, OWN0, OWN1. `gnt` outputs decode the state (registered). The memory-side outputs are a combinational mux of the owner's inputs.
- `last` register records the most recently served master. `beats` is a 4-bit counter of completed beats in the current ownership.
- IDLE:
  - One requester → OWN of that master.
  - Both requesters → OWN of the master ≠ `last`.
  - No requester → stay in IDLE.
- OWNx, beat completes (req high):
  - Increment `beats` and set `last` = x.
  - Other master requesting and (!lock_x or `beats`+1 ≥ MAX_BURST) → OWN other, `beats`=0.
  - Otherwise, req_x && lock_x → stay.
  - Otherwise, other requesting → OWN other.
  - Otherwise, req_x (unlocked, alone) → stay. Locking is only relevant under contention.
  - Otherwise → IDLE.
- OWNx, no req_x (master withdrew): no beat occurs. Go to OWN other if it requests, else IDLE; `beats`=0.
- Memory outputs when no beat is in progress (IDLE, or owner not requesting): address 0, wr_data 0, wr_enable 0, write_length 0. A write is never issued without gnt && req.
- Read beat (wr_enable=0): `i_mem_read_data` is captured into `o_mx_read_data` at the end of the beat, and `o_mx_rvalid`=1 for exactly the following cycle. Write beats produce no rvalid.
- `o_mx_read_data` holds its last value between reads.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert is the system's responsibility):
  - State IDLE, `last`=1 (so master 0 wins the first contention), `beats`=0.
  - All gnt/rvalid 0, all read_data 0, all mem outputs 0.
- Reset mid-beat aborts the access immediately. A pending rvalid is dropped and is not re-issued.
- Grant latency: req sampled high in IDLE at edge N → gnt high in cycle N+1. There is no bubble on a handover between OWN0 and OWN1.
- Throughput: one beat per cycle for the owner. A sole requester streams indefinitely.
- Read latency: beat in cycle k → rvalid and read_data in cycle k+1.
- Fairness bound: under continuous contention, a waiting master is granted within MAX_BURST+1 cycles.

## Test plan
- Reset then m0 single read of 0x100 (RAM word 0xDEADBEEF) → gnt0 in cycle 1, o_mem_address=0x100, rvalid0=1 and read_data0=0xDEADBEEF in cycle 2; m1 outputs stay 0.
- m0 and m1 request together from IDLE after reset, unlocked, continuously → grants alternate 0,1,0,1 each cycle with no idle cycle.
- m1 locked write burst of 8 beats while m0 requests constantly, MAX_BURST=4 → m1 gets 4 beats, m0 gets 1 beat, m1 resumes. o_mem_wr_enable is never 1 while gnt1=0.
- m0 raises req then drops it before its gnt cycle → no RAM access and no rvalid; the FSM returns to IDLE (or passes to m1 if m1 is requesting).
- Assert i_reset_n=0 asynchronously mid-cycle during an m1 read beat → all outputs 0 immediately, no rvalid1 afterwards. After release, the first contention is granted to m0.
- m0 write with write_length=3'b001 at 0x20 → o_mem_write_length=3'b001 and o_mem_wr_data equal to the input in the gnt cycle, no rvalid0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Shared bundle between the two bus masters, the arbiter and the RAM port.
// Handshake: a master holds i_mx_req until a cycle in which it also sees
// o_mx_gnt; that cycle (gnt && req at the rising edge) is one completed beat.
// A read beat returns o_mx_read_data with o_mx_rvalid high for exactly the
// following cycle.
interface mem_bus_arbiter_if;
    logic        i_m0_req;
    logic        i_m1_req;
    logic        i_m0_lock;
    logic        i_m1_lock;
    logic [31:0] i_m0_address;
    logic [31:0] i_m1_address;
    logic [31:0] i_m0_wr_data;
    logic [31:0] i_m1_wr_data;
    logic        i_m0_wr_enable;
    logic        i_m1_wr_enable;
    logic [2:0]  i_m0_write_length;
    logic [2:0]  i_m1_write_length;
    logic        o_m0_gnt;
    logic        o_m1_gnt;
    logic [31:0] o_m0_read_data;
    logic [31:0] o_m1_read_data;
    logic        o_m0_rvalid;
    logic        o_m1_rvalid;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_wr_data;
    logic        o_mem_wr_enable;
    logic [2:0]  o_mem_write_length;
    logic [31:0] i_mem_read_data;

    // Arbiter side: takes requests and RAM read data, drives grants and RAM.
    modport slave (
        input  i_m0_req, i_m1_req, i_m0_lock, i_m1_lock,
        input  i_m0_address, i_m1_address, i_m0_wr_data, i_m1_wr_data,
        input  i_m0_wr_enable, i_m1_wr_enable,
        input  i_m0_write_length, i_m1_write_length,
        input  i_mem_read_data,
        output o_m0_gnt, o_m1_gnt, o_m0_read_data, o_m1_read_data,
        output o_m0_rvalid, o_m1_rvalid,
        output o_mem_address, o_mem_wr_data, o_mem_wr_enable, o_mem_write_length
    );

    // Environment side: the masters plus the RAM read port.
    modport master (
        output i_m0_req, i_m1_req, i_m0_lock, i_m1_lock,
        output i_m0_address, i_m1_address, i_m0_wr_data, i_m1_wr_data,
        output i_m0_wr_enable, i_m1_wr_enable,
        output i_m0_write_length, i_m1_write_length,
        output i_mem_read_data,
        input  o_m0_gnt, o_m1_gnt, o_m0_read_data, o_m1_read_data,
        input  o_m0_rvalid, o_m1_rvalid,
        input  o_mem_address, o_mem_wr_data, o_mem_wr_enable, o_mem_write_length
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the main-memory data bus with a bounded
// burst lock. Grants decode the registered owner state; the RAM-side signals
// are a combinational mux of the owner's request, forced to zero whenever no
// beat is in progress so a write can never leak out without gnt && req.
module mem_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              i_reset_n,
    mem_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [4:0] MAX_BURST_W = 5'(MAX_BURST);

    state_t      state_q, state_d;
    logic        last_q, last_d;     // most recently served master
    logic [3:0]  beats_q, beats_d;   // beats completed in current ownership
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m0_rvalid_q, m0_rvalid_d;
    logic        m1_rvalid_q, m1_rvalid_d;

    logic        m0_beat;
    logic        m1_beat;
    logic [3:0]  beats_inc;
    logic        burst_done;

    assign m0_beat = (state_q == ST_OWN0) && bus.i_m0_req;
    assign m1_beat = (state_q == ST_OWN1) && bus.i_m1_req;

    // Counter saturates so a long uncontended locked stream cannot wrap
    // and later hold the bus past the burst limit.
    assign beats_inc  = (beats_q == 4'hF) ? 4'hF : beats_q + 4'd1;
    assign burst_done = ({1'b0, beats_q} + 5'd1) >= MAX_BURST_W;

    assign bus.o_m0_gnt       = (state_q == ST_OWN0);
    assign bus.o_m1_gnt       = (state_q == ST_OWN1);
    assign bus.o_m0_read_data = m0_rdata_q;
    assign bus.o_m1_read_data = m1_rdata_q;
    assign bus.o_m0_rvalid    = m0_rvalid_q;
    assign bus.o_m1_rvalid    = m1_rvalid_q;

    // RAM-side mux: only the owner's active beat reaches the memory.
    always_comb begin
        bus.o_mem_address      = 32'd0;
        bus.o_mem_wr_data      = 32'd0;
        bus.o_mem_wr_enable    = 1'b0;
        bus.o_mem_write_length = 3'd0;
        if (m0_beat) begin
            bus.o_mem_address      = bus.i_m0_address;
            bus.o_mem_wr_data      = bus.i_m0_wr_data;
            bus.o_mem_wr_enable    = bus.i_m0_wr_enable;
            bus.o_mem_write_length = bus.i_m0_write_length;
        end else if (m1_beat) begin
            bus.o_mem_address      = bus.i_m1_address;
            bus.o_mem_wr_data      = bus.i_m1_wr_data;
            bus.o_mem_wr_enable    = bus.i_m1_wr_enable;
            bus.o_mem_write_length = bus.i_m1_write_length;
        end
    end

    // Ownership next-state: round-robin from IDLE, lock honoured up to the
    // burst limit, immediate handover when the owner withdraws.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beats_d = beats_q;
        case (state_q)
            ST_IDLE: begin
                beats_d = 4'd0;
                if (bus.i_m0_req && bus.i_m1_req) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (bus.i_m0_req) begin
                    state_d = ST_OWN0;
                end else if (bus.i_m1_req) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (bus.i_m0_req) begin
                    last_d = 1'b0;
                    if (bus.i_m1_req && (!bus.i_m0_lock || burst_done)) begin
                        state_d = ST_OWN1;
                        beats_d = 4'd0;
                    end else begin
                        beats_d = beats_inc;
                    end
                end else begin
                    beats_d = 4'd0;
                    state_d = bus.i_m1_req ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (bus.i_m1_req) begin
                    last_d = 1'b1;
                    if (bus.i_m0_req && (!bus.i_m1_lock || burst_done)) begin
                        state_d = ST_OWN0;
                        beats_d = 4'd0;
                    end else begin
                        beats_d = beats_inc;
                    end
                end else begin
                    beats_d = 4'd0;
                    state_d = bus.i_m0_req ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beats_d = 4'd0;
            end
        endcase
    end

    // Read return: capture RAM data at the end of a read beat, strobe next cycle.
    always_comb begin
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_rvalid_d = m0_beat && !bus.i_m0_wr_enable;
        m1_rvalid_d = m1_beat && !bus.i_m1_wr_enable;
        if (m0_rvalid_d) begin
            m0_rdata_d = bus.i_mem_read_data;
        end
        if (m1_rvalid_d) begin
            m1_rdata_d = bus.i_mem_read_data;
        end
    end

    // State and read-return registers; reset drops any pending strobe.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            beats_q     <= 4'd0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            beats_q     <= beats_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change and outputs are checked
// on the falling edge; a small RAM model answers reads combinationally.
module tb_mem_bus_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // RAM: 0x100 holds 0xDEADBEEF, every other word reads as addr + 0x1000_0000.
    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'hDEAD_BEEF : addr + 32'h1000_0000;
    endfunction
    assign bus.i_mem_read_data = ram_word(bus.o_mem_address);

    // Clock: rising edges at 5, 15, 25 ...; falling edges at 10, 20, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic lock, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] wl);
        bus.i_m0_req          = req;
        bus.i_m0_lock         = lock;
        bus.i_m0_wr_enable    = wr;
        bus.i_m0_address      = addr;
        bus.i_m0_wr_data      = data;
        bus.i_m0_write_length = wl;
    endtask

    task automatic set_m1(input logic req, input logic lock, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] wl);
        bus.i_m1_req          = req;
        bus.i_m1_lock         = lock;
        bus.i_m1_wr_enable    = wr;
        bus.i_m1_address      = addr;
        bus.i_m1_wr_data      = data;
        bus.i_m1_write_length = wl;
    endtask

    initial begin
        logic [9:0]  exp_g1;
        logic [31:0] m1_addr;
        int          nb;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_m0(0, 0, 0, 32'h0, 32'h0, 3'd0);
        set_m1(0, 0, 0, 32'h0, 32'h0, 3'd0);

        // ---- reset state ----
        @(negedge clk); #1;
        chk("rst_gnt0",   32'(bus.o_m0_gnt), 32'd0);
        chk("rst_gnt1",   32'(bus.o_m1_gnt), 32'd0);
        chk("rst_rv0",    32'(bus.o_m0_rvalid), 32'd0);
        chk("rst_rd1",    bus.o_m1_read_data, 32'd0);
        chk("rst_maddr",  bus.o_mem_address, 32'd0);
        chk("rst_mwe",    32'(bus.o_mem_wr_enable), 32'd0);

        // ---- m0 single read of 0x100 ----
        @(negedge clk);
        rst_n = 1'b1;
        set_m0(1, 0, 0, 32'h100, 32'h0, 3'd0);
        @(negedge clk); #1;
        chk("t1_gnt0",  32'(bus.o_m0_gnt), 32'd1);
        chk("t1_gnt1",  32'(bus.o_m1_gnt), 32'd0);
        chk("t1_maddr", bus.o_mem_address, 32'h100);
        chk("t1_mwe",   32'(bus.o_mem_wr_enable), 32'd0);
        @(negedge clk);
        set_m0(0, 0, 0, 32'h0, 32'h0, 3'd0);
        #1;
        chk("t1_rv0",    32'(bus.o_m0_rvalid), 32'd1);
        chk("t1_rd0",    bus.o_m0_read_data, 32'hDEAD_BEEF);
        chk("t1_rv1",    32'(bus.o_m1_rvalid), 32'd0);
        chk("t1_rd1",    bus.o_m1_read_data, 32'd0);
        chk("t1_maddr0", bus.o_mem_address, 32'd0);
        @(negedge clk); #1;
        chk("t1_rv0_end", 32'(bus.o_m0_rvalid), 32'd0);
        chk("t1_gnt0_end", 32'(bus.o_m0_gnt), 32'd0);
        chk("t1_rd0_hold", bus.o_m0_read_data, 32'hDEAD_BEEF);

        // ---- m0 write, length code 001, at 0x20 ----
        set_m0(1, 0, 1, 32'h20, 32'hCAFE_F00D, 3'b001);
        @(negedge clk); #1;
        chk("t6_gnt0",  32'(bus.o_m0_gnt), 32'd1);
        chk("t6_maddr", bus.o_mem_address, 32'h20);
        chk("t6_mwd",   bus.o_mem_wr_data, 32'hCAFE_F00D);
        chk("t6_mwe",   32'(bus.o_mem_wr_enable), 32'd1);
        chk("t6_mwl",   32'(bus.o_mem_write_length), 32'd1);
        @(negedge clk);
        set_m0(0, 0, 0, 32'h0, 32'h0, 3'd0);
        #1;
        chk("t6_rv0",  32'(bus.o_m0_rvalid), 32'd0);
        chk("t6_rd0",  bus.o_m0_read_data, 32'hDEAD_BEEF);

        // ---- m1 locked 8-beat write burst with m0 contending ----
        @(negedge clk);
        set_m1(1, 1, 1, 32'h400, 32'hA000_0000, 3'b010);
        exp_g1 = 10'b01_1110_1111;
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) set_m0(1, 0, 0, 32'h500, 32'h0, 3'd0);
            m1_addr = 32'h400 + 32'(4 * nb);
            if (nb == 8) set_m1(0, 0, 0, 32'h0, 32'h0, 3'd0);
            else set_m1(1, 1, 1, m1_addr, 32'hA000_0000 + 32'(nb), 3'b010);
            #1;
            chk($sformatf("t3_gnt1_c%0d", c), 32'(bus.o_m1_gnt), 32'(exp_g1[c]));
            chk($sformatf("t3_gnt0_c%0d", c), 32'(bus.o_m0_gnt), 32'(!exp_g1[c]));
            chk($sformatf("t3_we_nognt_c%0d", c),
                32'(bus.o_mem_wr_enable & ~bus.o_m1_gnt), 32'd0);
            if (exp_g1[c]) begin
                chk($sformatf("t3_maddr_c%0d", c), bus.o_mem_address, m1_addr);
                nb++;
            end else begin
                chk($sformatf("t3_maddr_c%0d", c), bus.o_mem_address, 32'h500);
            end
        end
        @(negedge clk);
        set_m0(0, 0, 0, 32'h0, 32'h0, 3'd0);
        #1;
        chk("t3_rv0", 32'(bus.o_m0_rvalid), 32'd1);
        chk("t3_rd0", bus.o_m0_read_data, 32'h1000_0500);
        chk("t3_rv1", 32'(bus.o_m1_rvalid), 32'd0);

        // ---- m0 withdraws in its grant cycle, m1 takes over ----
        @(negedge clk);
        set_m0(1, 0, 1, 32'h700, 32'h1234_5678, 3'b011);
        @(negedge clk);
        set_m0(0, 0, 1, 32'h700, 32'h1234_5678, 3'b011);
        set_m1(1, 0, 0, 32'h600, 32'h0, 3'd0);
        #1;
        chk("t4_gnt0",  32'(bus.o_m0_gnt), 32'd1);
        chk("t4_mwe",   32'(bus.o_mem_wr_enable), 32'd0);
        chk("t4_maddr", bus.o_mem_address, 32'd0);
        chk("t4_mwd",   bus.o_mem_wr_data, 32'd0);
        @(negedge clk); #1;
        chk("t4_gnt1",   32'(bus.o_m1_gnt), 32'd1);
        chk("t4_gnt0b",  32'(bus.o_m0_gnt), 32'd0);
        chk("t4_rv0",    32'(bus.o_m0_rvalid), 32'd0);
        chk("t4_maddr1", bus.o_mem_address, 32'h600);
        @(negedge clk);
        set_m0(0, 0, 0, 32'h0, 32'h0, 3'd0);
        set_m1(0, 0, 0, 32'h0, 32'h0, 3'd0);
        #1;
        chk("t4_rv1", 32'(bus.o_m1_rvalid), 32'd1);
        chk("t4_rd1", bus.o_m1_read_data, 32'h1000_0600);
        @(negedge clk);

        // ---- asynchronous reset during an m1 read beat ----
        @(negedge clk);
        set_m1(1, 0, 0, 32'h800, 32'h0, 3'd0);
        @(negedge clk); #1;
        chk("t5_gnt1_pre",  32'(bus.o_m1_gnt), 32'd1);
        chk("t5_maddr_pre", bus.o_mem_address, 32'h800);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_gnt1",  32'(bus.o_m1_gnt), 32'd0);
        chk("t5_maddr", bus.o_mem_address, 32'd0);
        chk("t5_rd1",   bus.o_m1_read_data, 32'd0);
        chk("t5_rd0",   bus.o_m0_read_data, 32'd0);
        set_m1(0, 0, 0, 32'h0, 32'h0, 3'd0);
        @(negedge clk); #1;
        chk("t5_rv1_in_rst", 32'(bus.o_m1_rvalid), 32'd0);

        // ---- release, then continuous unlocked contention ----
        @(negedge clk);
        rst_n = 1'b1;
        set_m0(1, 0, 0, 32'h200, 32'h0, 3'd0);
        set_m1(1, 0, 0, 32'h300, 32'h0, 3'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk($sformatf("t2_gnt0_c%0d", c), 32'(bus.o_m0_gnt), 32'(c % 2 == 0));
            chk($sformatf("t2_gnt1_c%0d", c), 32'(bus.o_m1_gnt), 32'(c % 2 == 1));
            chk($sformatf("t2_maddr_c%0d", c), bus.o_mem_address,
                (c % 2 == 0) ? 32'h200 : 32'h300);
            chk($sformatf("t2_rv0_c%0d", c), 32'(bus.o_m0_rvalid), 32'(c % 2 == 1));
            chk($sformatf("t2_rv1_c%0d", c), 32'(bus.o_m1_rvalid),
                32'((c > 0) && (c % 2 == 0)));
        end
        chk("t2_rd0", bus.o_m0_read_data, 32'h1000_0200);
        chk("t2_rd1", bus.o_m1_read_data, 32'h1000_0300);
        @(negedge clk);
        set_m0(0, 0, 0, 32'h0, 32'h0, 3'd0);
        set_m1(0, 0, 0, 32'h0, 32'h0, 3'd0);
        #1;
        chk("t2_rv1_last", 32'(bus.o_m1_rvalid), 32'd1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
